input_conditioner: RTL

- Board-input front end that sits directly upstream of the Nios II SoC PIO ports.
- Takes the raw, asynchronous, bouncy SW[7:0] and KEY[1] (accumulate, active-low) pins and synchronizes and debounces them.
- Delivers clean levels to the switches and accumulate PIOs.
- Also provides a sticky accumulate request with a software/hardware acknowledge, so no button press is lost between polls.

---
 rtl/input_conditioner_pkg.sv | 19 +
 rtl/input_conditioner_if.sv | 45 ++++
 rtl/input_conditioner_debounce_channel.sv | 55 +++++
 rtl/input_conditioner.sv | 96 +++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the board-input conditioner.
// Optional feature macro used across these files: SW_CHANGE_EN.
package input_cond_pkg;

    localparam int NUM_SW_DEF          = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int SYNC_STAGES_DEF     = 2;

    typedef enum logic {
        ACC_IDLE,
        ACC_PENDING
    } acc_state_t;

    // Counter width for a debounce window; never below one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Board-side and PIO-side signals of the input conditioner.
// The sw_changed signal exists only when SW_CHANGE_EN is defined.
interface input_conditioner_if
    import input_cond_pkg::*;
#(
    parameter int NUM_SW = NUM_SW_DEF
);
    logic [NUM_SW-1:0] sw_raw;
    logic              key_n_raw;
    logic              acc_ack;
    logic [NUM_SW-1:0] sw_clean;
    logic              key_n_clean;
    logic              acc_press;
    logic              acc_req;
`ifdef SW_CHANGE_EN
    logic              sw_changed;
`endif

    modport master (
        input  sw_raw,
        input  key_n_raw,
        input  acc_ack,
        output sw_clean,
        output key_n_clean,
        output acc_press,
`ifdef SW_CHANGE_EN
        output sw_changed,
`endif
        output acc_req
    );

    modport slave (
        output sw_raw,
        output key_n_raw,
        output acc_ack,
        input  sw_clean,
        input  key_n_clean,
        input  acc_press,
`ifdef SW_CHANGE_EN
        input  sw_changed,
`endif
        input  acc_req
    );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One input bit: synchronizer chain, stability counter and clean register.
// The clean level follows the synchronized input only after DEBOUNCE_CYCLES unbroken samples.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic clean
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        clean_d = clean_q;
        cnt_d   = cnt_q;
        // Any sample equal to the clean level restarts the window.
        if (sync_last == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = sync_last;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            cnt_q   <= '0;
            clean_q <= RESET_VAL;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces SW[] and the active-low accumulate key, and keeps a sticky accumulate request.
// Define SW_CHANGE_EN to add the one-cycle sw_changed pulse on any clean switch change.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int NUM_SW          = NUM_SW_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input logic                 Clk,
    input logic                 Reset,
    input_conditioner_if.master bus
);

    logic [NUM_SW-1:0] sw_clean_w;
    logic              key_n_clean_w;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b0)
        ) u_ch (
            .Clk  (Clk),
            .Reset(Reset),
            .raw  (bus.sw_raw[i]),
            .clean(sw_clean_w[i])
        );
    end

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (1'b1)
    ) u_key (
        .Clk  (Clk),
        .Reset(Reset),
        .raw  (bus.key_n_raw),
        .clean(key_n_clean_w)
    );

    logic       key_prev_q, key_prev_d;
    logic       acc_press_q, acc_press_d;
    acc_state_t state_q, state_d;

    always_comb begin
        key_prev_d  = key_n_clean_w;
        acc_press_d = key_prev_q & ~key_n_clean_w;
        state_d     = state_q;
        // A press in the same cycle as an ack keeps the request pending.
        unique case (state_q)
            ACC_IDLE:    if (acc_press_q) state_d = ACC_PENDING;
            ACC_PENDING: if (bus.acc_ack && !acc_press_q) state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_prev_q  <= 1'b1;
            acc_press_q <= 1'b0;
            state_q     <= ACC_IDLE;
        end else begin
            key_prev_q  <= key_prev_d;
            acc_press_q <= acc_press_d;
            state_q     <= state_d;
        end
    end

`ifdef SW_CHANGE_EN
    logic [NUM_SW-1:0] sw_prev_q, sw_prev_d;
    logic              sw_changed_q, sw_changed_d;

    always_comb begin
        sw_prev_d    = sw_clean_w;
        sw_changed_d = |(sw_prev_q ^ sw_clean_w);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_prev_q    <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            sw_prev_q    <= sw_prev_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign bus.sw_changed = sw_changed_q;
`endif

    assign bus.sw_clean    = sw_clean_w;
    assign bus.key_n_clean = key_n_clean_w;
    assign bus.acc_press   = acc_press_q;
    assign bus.acc_req     = (state_q == ACC_PENDING);

endmodule
